rename_map_table: RTL
=====================

# rename_map_table

Registered register-alias table for the out-of-order MIPS core, with integrated physical free list and branch checkpoints. It sits between decode and the active list. Each cycle it renames one instruction: source lookup, destination allocation, and reporting of the previous mapping. It also recycles physical registers freed at commit. On a branch mispredict it restores the mapping and free list from a checkpoint in one cycle.

## Interface
Parameters:
- ARCH_REGS, 32, number of logical registers; logical 0 is $zero.
- PHYS_REGS, 64, number of physical registers; must exceed ARCH_REGS.
- CHECKPOINTS, 4, number of live branch checkpoints.
- Derived widths: AW = $clog2(ARCH_REGS), PW = $clog2(PHYS_REGS), CW = $clog2(CHECKPOINTS), FW = $clog2(PHYS_REGS+1).

Ports:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- rename_valid, in, 1, decode presents an instruction.
- rs_arch / rt_arch / rw_arch, in, AW each, logical source and destination registers.
- uses_rs / uses_rt / uses_rw, in, 1 each, operand use flags.
- checkpoint_req, in, 1, the instruction is a branch or jump; take a checkpoint.
- rename_ready, out, 1, the rename is accepted this cycle.
- rs_phys / rt_phys, out, PW each, physical sources; 0 when the matching uses flag is low.
- rw_phys, out, PW, allocated destination; 0 when there is no destination.
- prev_rw_phys, out, PW, mapping of rw_arch before this rename; sent to the active list.
- checkpoint_id, out, CW, checkpoint slot assigned to this branch.
- commit_valid, in, 1, the active list retires an entry that frees a register.
- commit_free_phys, in, PW, physical register to return to the free list.
- resolve_valid, in, 1, a branch has resolved.
- resolve_id, in, CW, checkpoint of the resolved branch.
- resolve_mispredict, in, 1, restore from resolve_id.
- free_count, out, FW, number of free physical registers (registered).
- ckpt_full, out, 1, all checkpoints are live.

## Operation
- Reset:
  - Map[i] = i. Physical 0..ARCH_REGS-1 are allocated; ARCH_REGS..PHYS_REGS-1 are free.
  - free_count = PHYS_REGS-ARCH_REGS. All checkpoints are dead, so ckpt_full = 0.
  - rename_ready = 0 while rst is high.
- Allocation is required when uses_rw = 1 and rw_arch != 0. Logical 0 is never renamed: rw_phys = 0, prev_rw_phys = 0.
- Allocation picks the lowest-index free physical register.
- rename_ready = !rst && !resolve_mispredict_fire && !(alloc && free_count == 0) && !(checkpoint_req && ckpt_full). It is combinational on the request inputs.
- A rename fires when rename_valid && rename_ready. At the clock edge:
  - Map[rw_arch] <= rw_phys.
  - The free bit for rw_phys is cleared.
  - The rw_phys bit is set in alloc_since[c] for every live checkpoint c.
- Checkpoints form an in-order circular buffer (head = oldest, tail = next slot to allocate).
  - On checkpoint_req fire, slot tail takes a snapshot of the map table *after* this instruction's own rename (so jal's $31 rename is preserved).
  - alloc_since[tail] is cleared, checkpoint_id = tail, and tail advances.
- Resolution must target head. A resolve_valid with resolve_id != head is ignored.
  - Correct prediction: head is retired (head++).
  - Mispredict:
    - Map <= snapshot[head].
    - free_list |= alloc_since[head].
    - All checkpoints are killed (head = tail).
    - A rename in the same cycle is rejected.
- Commit: on commit_valid, the free bit for commit_free_phys is set. Physical 0 is never freed; a commit of 0 is ignored.
- Simultaneous commit and mispredict: both frees are applied (OR).
- Simultaneous commit and rename: the committed register is not allocatable until the next cycle.
- free_count is updated every cycle by +commit −alloc + popcount(restored mask).

## Timing
- Lookup is combinational from registered state. rs_phys, rt_phys, rw_phys, prev_rw_phys and checkpoint_id are valid in the same cycle as rename_valid.
- Map updates are visible to a rename in cycle N+1. There is no same-cycle bypass, because there is one rename per cycle.
- A freed register becomes allocatable in cycle N+1 after the commit.
- Mispredict restore completes in one cycle; renames resume in cycle N+1 using the restored map.
- Reset asserted mid-operation discards all checkpoints and mappings on the next edge.

## Test plan
- Reset, then rename rw=5 (uses_rw) → rw_phys = 32, prev_rw_phys = 5, free_count 32→31. Next cycle rs=5 → rs_phys = 32.
- Rename rw=0 with uses_rw = 1 → rw_phys = 0, no allocation, free_count unchanged.
- Rename 32 destinations, then a 33rd → rename_ready = 0. Commit phys 7 → next cycle ready = 1 and rw_phys = 7.
- Branch at checkpoint 0, then rename rw=3 → phys 33. Mispredict id 0 → map[3] = 3 and free_count is restored. A later rename of rw=3 → rw_phys = 33.
- Fill 4 checkpoints → ckpt_full = 1, and a branch rename is stalled. Correct-resolve id 0 → ckpt_full = 0. Resolve of id 2 while head = 1 → ignored.
- Mispredict plus commit of phys 10 in the same cycle → both the restored registers and 10 are free; free_count is correct.

Source files
------------

// File: rtl/rename_map_table_if.sv
// Rename-stage bus between decode/active list and the register-alias table.
interface rename_map_table_if #(
    parameter int unsigned ARCH_REGS   = 32,
    parameter int unsigned PHYS_REGS   = 64,
    parameter int unsigned CHECKPOINTS = 4
);
    localparam int unsigned AW = $clog2(ARCH_REGS);
    localparam int unsigned PW = $clog2(PHYS_REGS);
    localparam int unsigned CW = $clog2(CHECKPOINTS);
    localparam int unsigned FW = $clog2(PHYS_REGS + 1);

    logic          rename_valid;
    logic [AW-1:0] rs_arch;
    logic [AW-1:0] rt_arch;
    logic [AW-1:0] rw_arch;
    logic          uses_rs;
    logic          uses_rt;
    logic          uses_rw;
    logic          checkpoint_req;
    logic          rename_ready;
    logic [PW-1:0] rs_phys;
    logic [PW-1:0] rt_phys;
    logic [PW-1:0] rw_phys;
    logic [PW-1:0] prev_rw_phys;
    logic [CW-1:0] checkpoint_id;
    logic          commit_valid;
    logic [PW-1:0] commit_free_phys;
    logic          resolve_valid;
    logic [CW-1:0] resolve_id;
    logic          resolve_mispredict;
    logic [FW-1:0] free_count;
    logic          ckpt_full;

    modport master (
        output rename_valid, rs_arch, rt_arch, rw_arch, uses_rs, uses_rt, uses_rw,
               checkpoint_req, commit_valid, commit_free_phys,
               resolve_valid, resolve_id, resolve_mispredict,
        input  rename_ready, rs_phys, rt_phys, rw_phys, prev_rw_phys, checkpoint_id,
               free_count, ckpt_full
    );

    modport slave (
        input  rename_valid, rs_arch, rt_arch, rw_arch, uses_rs, uses_rt, uses_rw,
               checkpoint_req, commit_valid, commit_free_phys,
               resolve_valid, resolve_id, resolve_mispredict,
        output rename_ready, rs_phys, rt_phys, rw_phys, prev_rw_phys, checkpoint_id,
               free_count, ckpt_full
    );
endinterface

// File: rtl/rename_map_table.sv
// Register-alias table with integrated free list and in-order branch checkpoints.
// One rename per cycle; mispredict restores map and free list in a single cycle.
module rename_map_table #(
    parameter int unsigned ARCH_REGS   = 32,
    parameter int unsigned PHYS_REGS   = 64,
    parameter int unsigned CHECKPOINTS = 4
) (
    input logic               clk,
    input logic               rst,
    rename_map_table_if.slave bus
);
    localparam int unsigned PW = $clog2(PHYS_REGS);
    localparam int unsigned CW = $clog2(CHECKPOINTS);
    localparam int unsigned FW = $clog2(PHYS_REGS + 1);

    logic [PW-1:0]        map_q   [ARCH_REGS];
    logic [PW-1:0]        map_n   [ARCH_REGS];
    logic [PW-1:0]        snap_q  [CHECKPOINTS][ARCH_REGS];
    logic [PHYS_REGS-1:0] alloc_since_q [CHECKPOINTS];
    logic [PHYS_REGS-1:0] alloc_since_n [CHECKPOINTS];
    logic [PHYS_REGS-1:0] free_q, free_n;
    logic [FW-1:0]        free_count_q, free_count_n;
    logic [CW-1:0]        head_q, head_n, tail_q, tail_n;
    logic [CW:0]          count_q, count_n;
    logic                 ckpt_full_q;

    logic                   alloc, resolve_fire, mispredict_fire;
    logic                   ready_c, rename_fire, ckpt_fire;
    logic [PW-1:0]          alloc_phys;
    logic [CHECKPOINTS-1:0] live;

    // Lowest-index free physical register.
    always_comb begin
        alloc_phys = '0;
        for (int i = int'(PHYS_REGS) - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_phys = PW'(i);
        end
    end

    // Slots between head (inclusive) and head+count are live.
    always_comb begin
        live = '0;
        for (int c = 0; c < int'(CHECKPOINTS); c++) begin
            live[c] = ((CW+1)'(CW'(CW'(c) - head_q)) < count_q);
        end
    end

    assign alloc           = bus.uses_rw && (bus.rw_arch != '0);
    assign resolve_fire    = bus.resolve_valid && (count_q != '0) && (bus.resolve_id == head_q);
    assign mispredict_fire = resolve_fire && bus.resolve_mispredict;
    assign ready_c         = !rst && !mispredict_fire
                             && !(alloc && (free_count_q == '0))
                             && !(bus.checkpoint_req && ckpt_full_q);
    assign rename_fire     = bus.rename_valid && ready_c;
    assign ckpt_fire       = rename_fire && bus.checkpoint_req;

    assign bus.rename_ready  = ready_c;
    assign bus.rs_phys       = bus.uses_rs ? map_q[bus.rs_arch] : '0;
    assign bus.rt_phys       = bus.uses_rt ? map_q[bus.rt_arch] : '0;
    assign bus.rw_phys       = alloc ? alloc_phys : '0;
    assign bus.prev_rw_phys  = alloc ? map_q[bus.rw_arch] : '0;
    assign bus.checkpoint_id = tail_q;
    assign bus.free_count    = free_count_q;
    assign bus.ckpt_full     = ckpt_full_q;

    always_comb begin
        map_n         = map_q;
        free_n        = free_q;
        alloc_since_n = alloc_since_q;
        head_n        = head_q;
        tail_n        = tail_q;
        count_n       = count_q;
        free_count_n  = '0;

        if (rename_fire && alloc) begin
            map_n[bus.rw_arch] = alloc_phys;
            free_n[alloc_phys] = 1'b0;
        end
        if (mispredict_fire) begin
            map_n  = snap_q[head_q];
            free_n = free_n | alloc_since_q[head_q];
        end
        if (bus.commit_valid && (bus.commit_free_phys != '0)) begin
            free_n[bus.commit_free_phys] = 1'b1;
        end

        // A new checkpoint starts with an empty mask: its own rename is in the snapshot.
        for (int c = 0; c < int'(CHECKPOINTS); c++) begin
            if (rename_fire && alloc && live[c]) alloc_since_n[c][alloc_phys] = 1'b1;
            if (ckpt_fire && (CW'(c) == tail_q)) alloc_since_n[c] = '0;
        end

        if (mispredict_fire) begin
            head_n  = tail_q;
            count_n = '0;
        end else begin
            if (resolve_fire) head_n = head_q + CW'(1);
            if (ckpt_fire)    tail_n = tail_q + CW'(1);
            count_n = count_q + (CW+1)'(ckpt_fire) - (CW+1)'(resolve_fire);
        end

        for (int i = 0; i < int'(PHYS_REGS); i++) begin
            free_count_n = free_count_n + FW'(free_n[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) map_q[i] <= PW'(i);
            for (int i = 0; i < int'(PHYS_REGS); i++) free_q[i] <= (i >= int'(ARCH_REGS));
            free_count_q <= FW'(PHYS_REGS - ARCH_REGS);
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ckpt_full_q  <= 1'b0;
        end else begin
            map_q        <= map_n;
            free_q       <= free_n;
            free_count_q <= free_count_n;
            head_q       <= head_n;
            tail_q       <= tail_n;
            count_q      <= count_n;
            ckpt_full_q  <= (count_n == (CW+1)'(CHECKPOINTS));
        end
    end

    // Snapshot storage needs no reset: a slot is only read after it is written.
    always_ff @(posedge clk) begin
        alloc_since_q <= alloc_since_n;
        if (ckpt_fire) snap_q[tail_q] <= map_n;
    end
endmodule
